// File: rtl/mem_cfg_pkg.sv
// rtl/mem_cfg_pkg.sv - shared memory-access types for interleaved_memory and its LSU front end
// Purpose: access width encoding, LSU state encoding and the width-to-byte-count helper.
// Ports: none (package).
package mem_cfg_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } mem_width_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   // Number of bytes touched by an access of the given width.
   function automatic logic [2:0] width_bytes(input mem_width_t w);
      case (w)
         BYTE:    width_bytes = 3'd1;
         HALF:    width_bytes = 3'd2;
         default: width_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_check.sv
// rtl/mem_access_check.sv - combinational legality check for one LSU access
// Purpose: flags accesses that run past the end of a 2**ADDR_W byte memory.
//          With MEM_LSU_MISALIGN_TRAP_EN defined, misaligned HALF/WORD accesses are flagged too.
// Ports:
//   i_addr  [ADDR_W-1:0]  byte address of the access
//   i_width mem_width_t   access width
//   o_err   1             access must be rejected
module mem_access_check
   import mem_cfg_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  mem_width_t        i_width,
   output logic              o_err
);

   localparam logic [ADDR_W:0] MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] w_bytes;
   logic [ADDR_W:0] w_end;
   logic            w_misalign;

   // End address is computed one bit wider than the address so it cannot wrap.
   always_comb begin
      w_bytes      = '0;
      w_bytes[2:0] = width_bytes(i_width);
      w_end        = {1'b0, i_addr} + w_bytes;
   end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
   assign w_misalign = ((i_width == HALF) && i_addr[0]) ||
                       ((i_width == WORD) && (i_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign o_err = (w_end > MEM_BYTES) || w_misalign;

endmodule

// File: rtl/mem_lsu_adapter.sv
// rtl/mem_lsu_adapter.sv - single-outstanding load/store front end for interleaved_memory
// Purpose: accepts one request at a time, drives the memory port from registers, waits out the
//          memory read latency and presents the result in a held response register.
//          Optional macro MEM_LSU_MISALIGN_TRAP_EN (in mem_access_check) rejects misaligned accesses.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   req_valid_i/req_ready_o          request handshake
//   req_addr_i/we/width/sign/data    request fields
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_data_o, rsp_err_o            load data (0 for stores/errors), rejection flag
//   mem_addr_o/width/sign_extend/we/data_o, mem_data_i   memory port
module mem_lsu_adapter
   import mem_cfg_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int READ_LATENCY = 1    // 1..4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic              req_we_i,
   input  mem_width_t        req_width_i,
   input  logic              req_sign_i,
   input  logic [31:0]       req_data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_data_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output mem_width_t        mem_width_o,
   output logic              mem_sign_extend_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_data_o,
   input  logic [31:0]       mem_data_i
);

   localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

   lsu_state_t        r_state;
   lsu_state_t        w_next;
   logic              w_req_ready;
   logic              w_rsp_valid;
   logic              w_err;

   logic [ADDR_W-1:0] r_mem_addr;
   mem_width_t        r_mem_width;
   logic              r_mem_sign;
   logic              r_mem_we;
   logic [31:0]       r_mem_data;
   logic [1:0]        r_cnt;
   logic [31:0]       r_rsp_data;
   logic              r_rsp_err;

   mem_access_check #(
      .ADDR_W (ADDR_W)
   ) u_check (
      .i_addr  (req_addr_i),
      .i_width (req_width_i),
      .o_err   (w_err)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_req_ready = 1'b1;
            if (req_valid_i) begin
               w_next = w_err ? RESP : ACCESS;
            end
         end
         // r_mem_we still holds the registered request type during ACCESS.
         ACCESS:  w_next = r_mem_we ? RESP : WAIT;
         WAIT: begin
            if (r_cnt == LAST_CNT) begin
               w_next = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (rsp_ready_i) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // The memory port registers double as the request register, so the ACCESS cycle
   // sees the accepted request directly and WAIT holds address/width/sign for free.
   // Rejected requests leave the memory port untouched.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mem_addr  <= '0;
         r_mem_width <= BYTE;
         r_mem_sign  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_data  <= '0;
         r_cnt       <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  if (w_err) begin
                     r_rsp_err  <= 1'b1;
                     r_rsp_data <= '0;
                  end else begin
                     r_mem_addr  <= req_addr_i;
                     r_mem_width <= req_width_i;
                     r_mem_sign  <= req_sign_i;
                     r_mem_data  <= req_data_i;
                     r_mem_we    <= req_we_i;
                  end
               end
            end
            ACCESS: begin
               r_mem_we <= 1'b0;
               r_cnt    <= '0;
               if (r_mem_we) begin
                  r_rsp_data <= '0;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt + 2'd1;
               if (r_cnt == LAST_CNT) begin
                  r_rsp_data <= mem_data_i;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o       = w_req_ready;
   assign rsp_valid_o       = w_rsp_valid;
   assign rsp_data_o        = r_rsp_data;
   assign rsp_err_o         = r_rsp_err;
   assign mem_addr_o        = r_mem_addr;
   assign mem_width_o       = r_mem_width;
   assign mem_sign_extend_o = r_mem_sign;
   assign mem_we_o          = r_mem_we;
   assign mem_data_o        = r_mem_data;

endmodule
